ahb_bus_arbiter: RTL and testbench

AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

---
 rtl/ahb_bus_arbiter.sv | 115 +++++++++++
 tb/tb_ahb_bus_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: registered one-hot round-robin grant with locked hold and RETRY/SPLIT handling.
// Optional split-mask support is compiled in when AHB_ARB_SPLIT_EN is defined.
module ahb_bus_arbiter #(
    parameter int NO_OF_MASTERS  = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic [NO_OF_MASTERS-1:0]         HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0]         HLOCK,
    input  logic [NO_OF_MASTERS-1:0]         HSPLIT,
    input  logic [1:0]                       HTRANS,
    input  logic                             HREADY,
    input  logic [1:0]                       HRESP,
    output logic [NO_OF_MASTERS-1:0]         HGRANT,
    output logic [$clog2(NO_OF_MASTERS)-1:0] HMASTER,
    output logic                             HMASTLOCK
);

    localparam int N  = NO_OF_MASTERS;
    localparam int MW = $clog2(NO_OF_MASTERS);
    localparam logic [N-1:0]  RST_GRANT = N'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0] RST_IDX   = MW'(DEFAULT_MASTER);

    logic [N-1:0]  grant_q, grant_d;
    logic [MW-1:0] ptr_q, ptr_d;
    logic [MW-1:0] master_q, master_d;
    logic          mastlock_q, mastlock_d;

    logic [N-1:0]  elig;
    logic          force_arb;
    logic          arb;
    logic [MW-1:0] sel;
    logic          found;
    logic [MW:0]   cand;

`ifdef AHB_ARB_SPLIT_EN
    logic [N-1:0] mask_q, mask_d;
    logic [N-1:0] set_vec;
    logic         unused_in;

    assign unused_in = HTRANS[1];

    always_comb begin
        set_vec = '0;
        if (HREADY && HRESP == 2'b11) set_vec[master_q] = 1'b1;
        // A resume pulse wins over a split landing on the same bit.
        mask_d = (mask_q | set_vec) & ~HSPLIT;
        elig   = HBUSREQ & ~(mask_q | set_vec);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) mask_q <= '0;
        else          mask_q <= mask_d;
    end
`else
    logic unused_in;

    assign unused_in = ^{HSPLIT, HRESP[0], HTRANS[1]};
    assign elig      = HBUSREQ;
`endif

    // RETRY and SPLIT (both HRESP[1]=1) break into a burst, never into a locked hold.
    assign force_arb = HREADY && HRESP[1];
    assign arb       = HREADY && !HLOCK[ptr_q] && (!HTRANS[0] || force_arb);

    always_comb begin
        sel   = RST_IDX;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, ptr_q} + (MW+1)'(i);
            if (cand >= (MW+1)'(N)) cand = cand - (MW+1)'(N);
            if (!found && elig[cand[MW-1:0]]) begin
                sel   = cand[MW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        master_d   = master_q;
        mastlock_d = mastlock_q;
        if (arb) begin
            grant_d      = '0;
            grant_d[sel] = 1'b1;
            ptr_d        = sel;
        end
        if (HREADY) begin
            master_d   = ptr_q;
            mastlock_d = HLOCK[ptr_q];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q    <= RST_GRANT;
            ptr_q      <= RST_IDX;
            master_q   <= RST_IDX;
            mastlock_q <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            master_q   <= master_d;
            mastlock_q <= mastlock_d;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = master_q;
    assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (4 masters, default master 0).
// Split-mask expectations follow AHB_ARB_SPLIT_EN when it is defined.
module tb_ahb_bus_arbiter;

    localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [1:0] OK = 2'b00, ERR = 2'b01, RTY = 2'b10, SPL = 2'b11;

    logic       HCLK;
    logic       HRESETn;
    logic [3:0] HBUSREQ, HLOCK, HSPLIT;
    logic [1:0] HTRANS, HRESP;
    logic       HREADY;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    int n_cmp = 0;
    int n_err = 0;

    ahb_bus_arbiter #(.NO_OF_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HSPLIT(HSPLIT),
        .HTRANS(HTRANS), .HREADY(HREADY), .HRESP(HRESP),
        .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic cyc(input logic [3:0] req, input logic [3:0] lck,
                       input logic [3:0] spl, input logic [1:0] tr,
                       input logic rdy, input logic [1:0] rsp);
        HBUSREQ = req;
        HLOCK   = lck;
        HSPLIT  = spl;
        HTRANS  = tr;
        HREADY  = rdy;
        HRESP   = rsp;
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] g,
                       input logic [1:0] m, input logic l);
        n_cmp++;
        assert (HGRANT === g) else begin
            n_err++;
            $error("FAIL %s HGRANT obs=%b exp=%b", tag, HGRANT, g);
        end
        n_cmp++;
        assert (HMASTER === m) else begin
            n_err++;
            $error("FAIL %s HMASTER obs=%0d exp=%0d", tag, HMASTER, m);
        end
        n_cmp++;
        assert (HMASTLOCK === l) else begin
            n_err++;
            $error("FAIL %s HMASTLOCK obs=%b exp=%b", tag, HMASTLOCK, l);
        end
    endtask

    initial begin
        HRESETn = 1'b0;
        HBUSREQ = '0; HLOCK = '0; HSPLIT = '0;
        HTRANS = IDLE; HREADY = 1'b1; HRESP = OK;
        #12;
        chk("reset", 4'b0001, 2'd0, 1'b0);
        HRESETn = 1'b1;

        cyc(4'b0000, 4'b0, 4'b0, IDLE, 1, OK); chk("idle_dflt", 4'b0001, 2'd0, 0);

        cyc(4'b1111, 4'b0, 4'b0, NSEQ, 1, OK); chk("rr1", 4'b0010, 2'd0, 0);
        cyc(4'b1111, 4'b0, 4'b0, NSEQ, 1, OK); chk("rr2", 4'b0100, 2'd1, 0);
        cyc(4'b1111, 4'b0, 4'b0, NSEQ, 1, OK); chk("rr3", 4'b1000, 2'd2, 0);
        cyc(4'b1111, 4'b0, 4'b0, NSEQ, 1, OK); chk("rr0", 4'b0001, 2'd3, 0);
        cyc(4'b1111, 4'b0, 4'b0, NSEQ, 1, OK); chk("rr1b", 4'b0010, 2'd0, 0);

        cyc(4'b0100, 4'b0, 4'b0, IDLE, 1, OK); chk("to_m2", 4'b0100, 2'd1, 0);
        cyc(4'b0100, 4'b0, 4'b0, IDLE, 1, OK); chk("m2_own", 4'b0100, 2'd2, 0);
        cyc(4'b0100, 4'b0, 4'b0, NSEQ, 1, OK); chk("b_beat1", 4'b0100, 2'd2, 0);
        cyc(4'b1111, 4'b0, 4'b0, SEQ, 0, OK);  chk("b_wait", 4'b0100, 2'd2, 0);
        cyc(4'b1111, 4'b0, 4'b0, SEQ, 1, OK);  chk("b_beat2", 4'b0100, 2'd2, 0);
        cyc(4'b1111, 4'b0, 4'b0, SEQ, 1, OK);  chk("b_beat3", 4'b0100, 2'd2, 0);
        cyc(4'b1111, 4'b0, 4'b0, SEQ, 1, OK);  chk("b_beat4", 4'b0100, 2'd2, 0);
        cyc(4'b1111, 4'b0, 4'b0, IDLE, 1, OK); chk("b_done", 4'b1000, 2'd2, 0);
        cyc(4'b1111, 4'b0, 4'b0, IDLE, 0, OK); chk("frz", 4'b1000, 2'd2, 0);
        cyc(4'b1000, 4'b0, 4'b0, IDLE, 1, OK); chk("m3_own", 4'b1000, 2'd3, 0);

        cyc(4'b0010, 4'b0010, 4'b0, IDLE, 1, OK); chk("lk_gnt", 4'b0010, 2'd3, 0);
        cyc(4'b1111, 4'b0010, 4'b0, NSEQ, 1, OK); chk("lk_t1", 4'b0010, 2'd1, 1);
        cyc(4'b1111, 4'b0010, 4'b0, NSEQ, 1, OK); chk("lk_t2", 4'b0010, 2'd1, 1);
        cyc(4'b1111, 4'b0010, 4'b0, NSEQ, 1, OK); chk("lk_t3", 4'b0010, 2'd1, 1);
        cyc(4'b1111, 4'b0000, 4'b0, NSEQ, 1, OK); chk("lk_rel", 4'b0100, 2'd1, 0);

        cyc(4'b1111, 4'b0, 4'b0, SEQ, 1, OK);  chk("seq_hold", 4'b0100, 2'd2, 0);
        cyc(4'b1111, 4'b0, 4'b0, SEQ, 1, RTY); chk("retry", 4'b1000, 2'd2, 0);
        cyc(4'b1111, 4'b0, 4'b0, SEQ, 1, ERR); chk("error", 4'b1000, 2'd3, 0);
        cyc(4'b1000, 4'b0, 4'b0, SEQ, 1, RTY); chk("rty_elig", 4'b1000, 2'd3, 0);

`ifdef AHB_ARB_SPLIT_EN
        cyc(4'b1000, 4'b0, 4'b0000, NSEQ, 1, SPL); chk("split", 4'b0001, 2'd3, 0);
        cyc(4'b1000, 4'b0, 4'b0000, IDLE, 1, OK);  chk("sp_mask", 4'b0001, 2'd0, 0);
        cyc(4'b1000, 4'b0, 4'b1000, IDLE, 1, OK);  chk("sp_res", 4'b0001, 2'd0, 0);
        cyc(4'b1000, 4'b0, 4'b0000, IDLE, 1, OK);  chk("sp_back", 4'b1000, 2'd0, 0);
`else
        cyc(4'b1000, 4'b0, 4'b0000, NSEQ, 1, SPL); chk("split", 4'b1000, 2'd3, 0);
        cyc(4'b1000, 4'b0, 4'b0000, IDLE, 1, OK);  chk("sp_mask", 4'b1000, 2'd3, 0);
        cyc(4'b1000, 4'b0, 4'b1000, IDLE, 1, OK);  chk("sp_res", 4'b1000, 2'd3, 0);
        cyc(4'b1000, 4'b0, 4'b0000, IDLE, 1, OK);  chk("sp_back", 4'b1000, 2'd3, 0);
`endif

        cyc(4'b0100, 4'b0100, 4'b0, IDLE, 1, OK); chk("r_gnt", 4'b0100, 2'd3, 0);
        cyc(4'b0100, 4'b0100, 4'b0, IDLE, 1, OK); chk("r_own", 4'b0100, 2'd2, 1);
        cyc(4'b1111, 4'b0100, 4'b0, NSEQ, 1, OK); chk("r_b1", 4'b0100, 2'd2, 1);
        cyc(4'b1111, 4'b0100, 4'b0, SEQ, 1, OK);  chk("r_b2", 4'b0100, 2'd2, 1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("async_rst", 4'b0001, 2'd0, 0);
        #2;
        HRESETn = 1'b1;
        cyc(4'b1111, 4'b0, 4'b0, IDLE, 1, OK); chk("resume", 4'b0010, 2'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
